// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer: loads operands/opcode for a downstream ALU, runs one execute, holds the result until consumed
//   clk, rst_n           clock, asynchronous active-low reset
//   cmd_valid/cmd_ready  command handshake; cmd_type 00 load A, 01 load B, 10 execute, 11 clear
//   cmd_data             operand for loads, opcode in [1:0] for execute
//   alu_in1/alu_in0      operand A/B registers feeding the ALU
//   alu_opcode           opcode register (00 add, 01 or, 10 sub, 11 xor)
//   alu_out              combinational ALU result
//   res_valid/res_ready  result handshake; res_data is the captured result
//   exec_count           completed result transfers, wraps at 256
module alu_operand_sequencer #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_type,
    input  logic [N-1:0] cmd_data,
    output logic [N-1:0] alu_in1,
    output logic [N-1:0] alu_in0,
    output logic [1:0]   alu_opcode,
    input  logic [N-1:0] alu_out,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [N-1:0] res_data,
    output logic [7:0]   exec_count
);
    typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;
    state_t state, state_nxt;
    logic [N-1:0] a, b;
    logic [1:0] op;
    // armed stays low through reset and rises on the first edge after release
    logic armed;
    logic cmd_xfer;
    assign cmd_ready  = (state == IDLE) && armed;
    assign res_valid  = (state == HOLD);
    assign cmd_xfer   = cmd_valid && cmd_ready;
    assign alu_in1    = a;
    assign alu_in0    = b;
    assign alu_opcode = op;
    always_comb begin
        state_nxt = (state == IDLE) ? ((cmd_xfer && cmd_type == 2'b10) ? EXEC : IDLE) :
                    (state == EXEC) ? HOLD :
                    (res_ready ? IDLE : HOLD);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            armed      <= 1'b0;
            a          <= '0;
            b          <= '0;
            op         <= '0;
            res_data   <= '0;
            exec_count <= '0;
        end else begin
            armed <= 1'b1;
            state <= state_nxt;
            if (cmd_xfer) begin
                case (cmd_type)
                    2'b00: a <= cmd_data;
                    2'b01: b <= cmd_data;
                    2'b10: op <= cmd_data[1:0];
                    default: begin
                        a  <= '0;
                        b  <= '0;
                        op <= '0;
                    end
                endcase
            end
            // result feeds back into A so successive executes chain
            if (state == EXEC) begin
                res_data <= alu_out;
                a        <= alu_out;
            end
            if (state == HOLD && res_ready)
                exec_count <= exec_count + 8'd1;
        end
    end
endmodule

// File: tb/tb_alu_operand_sequencer.sv
// tb_alu_operand_sequencer: randomized and directed checks against a behavioural model of the sequencer
module tb_alu_operand_sequencer;
    localparam int N = 3;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [1:0]   cmd_type = '0;
    logic [N-1:0] cmd_data = '0;
    logic [N-1:0] alu_in1, alu_in0, alu_out, res_data;
    logic [1:0]   alu_opcode;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [7:0]   exec_count;
    int checks = 0;
    int errors = 0;
    int m_a = 0, m_b = 0, m_op = 0, m_cnt = 0;

    alu_operand_sequencer #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_type(cmd_type), .cmd_data(cmd_data), .alu_in1(alu_in1), .alu_in0(alu_in0),
        .alu_opcode(alu_opcode), .alu_out(alu_out), .res_valid(res_valid),
        .res_ready(res_ready), .res_data(res_data), .exec_count(exec_count)
    );

    always #5 clk = ~clk;

    function automatic int ref_alu(input int x, input int y, input int o);
        case (o)
            0: return (x + y) % 8;
            1: return x | y;
            2: return (x - y + 8) % 8;
            default: return x ^ y;
        endcase
    endfunction

    assign alu_out = N'(ref_alu(int'(alu_in1), int'(alu_in0), int'(alu_opcode)));

    task automatic do_cmd(input int t, input int d);
        cmd_valid = 1'b1;
        cmd_type  = 2'(t);
        cmd_data  = N'(d);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        case (t)
            0: m_a = d % 8;
            1: m_b = d % 8;
            2: m_op = d % 4;
            default: begin m_a = 0; m_b = 0; m_op = 0; end
        endcase
        checks++;
        if (alu_in1 !== N'(m_a) || alu_in0 !== N'(m_b) || alu_opcode !== 2'(m_op)) begin
            errors++;
            $display("FAIL cmd_regs type=%0d got A=%0d B=%0d op=%0d want A=%0d B=%0d op=%0d",
                     t, alu_in1, alu_in0, alu_opcode, m_a, m_b, m_op);
        end
        checks++;
        if (cmd_ready !== (t != 2)) begin
            errors++;
            $display("FAIL cmd_ready_after type=%0d got %0b", t, cmd_ready);
        end
    endtask

    task automatic run_exec(input int opd, input int hold, output int res);
        int exp;
        exp = ref_alu(m_a, m_b, opd % 4);
        do_cmd(2, opd);
        checks++;
        if (res_valid !== 1'b0) begin
            errors++;
            $display("FAIL exec_res_valid got %0b want 0", res_valid);
        end
        @(posedge clk); #1;
        m_a = exp;
        checks++;
        if (res_valid !== 1'b1 || res_data !== N'(exp)) begin
            errors++;
            $display("FAIL exec_result got v=%0b d=%0d want v=1 d=%0d", res_valid, res_data, exp);
        end
        checks++;
        if (alu_in1 !== N'(m_a) || alu_in0 !== N'(m_b) || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL exec_chain got A=%0d B=%0d rdy=%0b want A=%0d B=%0d rdy=0",
                     alu_in1, alu_in0, cmd_ready, m_a, m_b);
        end
        repeat (hold) begin
            cmd_valid = 1'b1;
            cmd_type  = 2'($urandom);
            cmd_data  = N'($urandom);
            @(posedge clk); #1;
            cmd_valid = 1'b0;
            checks++;
            if (res_valid !== 1'b1 || res_data !== N'(exp) || cmd_ready !== 1'b0 ||
                exec_count !== 8'(m_cnt) || alu_in1 !== N'(m_a) || alu_in0 !== N'(m_b) ||
                alu_opcode !== 2'(m_op)) begin
                errors++;
                $display("FAIL hold_stable got v=%0b d=%0d rdy=%0b cnt=%0d A=%0d B=%0d want v=1 d=%0d rdy=0 cnt=%0d A=%0d B=%0d",
                         res_valid, res_data, cmd_ready, exec_count, alu_in1, alu_in0, exp, m_cnt, m_a, m_b);
            end
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        m_cnt = (m_cnt + 1) % 256;
        checks++;
        if (res_valid !== 1'b0 || cmd_ready !== 1'b1 || exec_count !== 8'(m_cnt)) begin
            errors++;
            $display("FAIL result_xfer got v=%0b rdy=%0b cnt=%0d want v=0 rdy=1 cnt=%0d",
                     res_valid, cmd_ready, exec_count, m_cnt);
        end
        res = exp;
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if (cmd_ready !== 1'b0 || res_valid !== 1'b0 || alu_in1 !== '0 || alu_in0 !== '0 ||
            alu_opcode !== '0 || res_data !== '0 || exec_count !== '0) begin
            errors++;
            $display("FAIL reset_state rdy=%0b v=%0b A=%0d B=%0d op=%0d d=%0d cnt=%0d",
                     cmd_ready, res_valid, alu_in1, alu_in0, alu_opcode, res_data, exec_count);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_edge got %0b want 0", cmd_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_edge got %0b want 1", cmd_ready);
        end
    endtask

    task automatic test_add_wrap;
        int r;
        do_cmd(0, 5);
        do_cmd(1, 3);
        run_exec(0, 0, r);
        checks++;
        if (r != 0 || alu_in1 !== '0) begin
            errors++;
            $display("FAIL add_wrap got res=%0d A=%0d want 0 0", r, alu_in1);
        end
    endtask

    task automatic test_sub_chain;
        int r;
        do_cmd(0, 2);
        do_cmd(1, 3);
        run_exec(2, 0, r);
        checks++;
        if (r != 7) begin
            errors++;
            $display("FAIL sub_wrap got %0d want 7", r);
        end
        run_exec(3, 0, r);
        checks++;
        if (r != 4) begin
            errors++;
            $display("FAIL xor_chain got %0d want 4", r);
        end
    endtask

    task automatic test_hold;
        int r;
        run_exec(1, 5, r);
    endtask

    task automatic test_res_ready_idle;
        res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        res_ready = 1'b0;
        checks++;
        if (exec_count !== 8'(m_cnt) || res_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL res_ready_idle got cnt=%0d v=%0b rdy=%0b want cnt=%0d v=0 rdy=1",
                     exec_count, res_valid, cmd_ready, m_cnt);
        end
    endtask

    task automatic test_clear;
        int r;
        do_cmd(0, 6);
        do_cmd(1, 1);
        do_cmd(3, 7);
        run_exec(1, 0, r);
        checks++;
        if (r != 0) begin
            errors++;
            $display("FAIL clear_then_or got %0d want 0", r);
        end
    endtask

    task automatic test_random;
        int r;
        for (int i = 0; i < 60; i++) begin
            int t;
            t = int'($urandom_range(0, 3));
            if (t == 2) run_exec(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), r);
            else do_cmd(t, int'($urandom_range(0, 7)));
        end
    endtask

    task automatic test_abort;
        do_cmd(0, 4);
        do_cmd(1, 2);
        do_cmd(2, 0);
        @(posedge clk); #1;
        checks++;
        if (res_valid !== 1'b1) begin
            errors++;
            $display("FAIL abort_in_hold got v=%0b want 1", res_valid);
        end
        res_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (res_valid !== 1'b0 || cmd_ready !== 1'b0 || alu_in1 !== '0 || alu_in0 !== '0 ||
            alu_opcode !== '0 || res_data !== '0 || exec_count !== '0) begin
            errors++;
            $display("FAIL abort_async v=%0b rdy=%0b A=%0d B=%0d op=%0d d=%0d cnt=%0d",
                     res_valid, cmd_ready, alu_in1, alu_in0, alu_opcode, res_data, exec_count);
        end
        @(posedge clk); #1;
        res_ready = 1'b0;
        checks++;
        if (exec_count !== '0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_xfer got cnt=%0d v=%0b want 0 0", exec_count, res_valid);
        end
        rst_n = 1'b1;
        m_a = 0; m_b = 0; m_op = 0; m_cnt = 0;
        @(posedge clk); #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_recover got rdy=%0b want 1", cmd_ready);
        end
    endtask

    task automatic test_count_wrap;
        int r;
        for (int i = 0; i < 256; i++) begin
            run_exec(int'($urandom_range(0, 3)), 0, r);
            if (i == 254) begin
                checks++;
                if (exec_count !== 8'd255) begin
                    errors++;
                    $display("FAIL count_255 got %0d want 255", exec_count);
                end
            end
        end
        checks++;
        if (exec_count !== 8'd0) begin
            errors++;
            $display("FAIL count_wrap got %0d want 0", exec_count);
        end
    endtask

    initial begin
        test_reset();
        test_add_wrap();
        test_sub_chain();
        test_hold();
        test_res_ready_idle();
        test_clear();
        test_random();
        test_abort();
        test_count_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
